rx_on_detection: RTL

- Receive-direction counterpart of the TX on/off detector in the xpu.
- Tracks one baseband receive burst from PHY start/done indications and the RX IQ sample strobe.
- Suppresses self-reception while our own RF TX is on, and runs a microsecond watchdog for a missing done indication.
- Produces an extended "RX busy" window used by the MAC timing logic (SIFS/CCA), plus a sample count and end-cause pulses.

---
 rtl/rx_on_detection_pkg.sv | 16 +
 rtl/rx_on_detection_if.sv | 33 +++
 rtl/rx_on_detection_us_watchdog.sv | 30 +++
 rtl/rx_on_detection.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/rx_on_detection_pkg.sv
// Shared xpu definitions for the RX on/off detector: FSM encodings, scaled-count
// width and the default clock-cycles-per-delay-unit factor.
package rx_on_detection_pkg;
  localparam int SCALED_W        = 14;
  localparam int COUNT_SCALE_DEF = 10;

  typedef enum logic [1:0] {
    RX_DET_IDLE   = 2'd0,
    RX_DET_ACTIVE = 2'd1,
    RX_DET_TAIL   = 2'd2
  } rx_det_state_e;

  function automatic logic [SCALED_W-1:0] scale_count(input logic [7:0] top, input int k);
    return SCALED_W'(top) * SCALED_W'(k);
  endfunction
endpackage

// File: rtl/rx_on_detection_if.sv
// PHY/MAC-facing signal bundle of the RX on/off detector; master is the xpu
// side driving PHY indications, slave is the detector.
interface rx_on_detection_if #(parameter int SAMPLE_CNT_W = 16);
  logic [7:0]              bb_rf_delay_count_top;
  logic [3:0]              rx_end_ext_count_top;
  logic [15:0]             rx_timeout_count_top;
  logic                    tsf_pulse_1M;
  logic                    tx_rf_is_ongoing;
  logic                    phy_rx_started;
  logic                    phy_rx_done;
  logic                    rx_iq_valid;
  logic                    rx_bb_is_ongoing;
  logic                    rx_busy_ext;
  logic                    pulse_rx_bb_end;
  logic                    rx_timeout_pulse;
  logic                    rx_abort_by_tx;
  logic [13:0]             rx_rf_end_delay;
  logic [SAMPLE_CNT_W-1:0] rx_sample_count;

  modport master (
    output bb_rf_delay_count_top, rx_end_ext_count_top, rx_timeout_count_top,
           tsf_pulse_1M, tx_rf_is_ongoing, phy_rx_started, phy_rx_done, rx_iq_valid,
    input  rx_bb_is_ongoing, rx_busy_ext, pulse_rx_bb_end, rx_timeout_pulse,
           rx_abort_by_tx, rx_rf_end_delay, rx_sample_count
  );

  modport slave (
    input  bb_rf_delay_count_top, rx_end_ext_count_top, rx_timeout_count_top,
           tsf_pulse_1M, tx_rf_is_ongoing, phy_rx_started, phy_rx_done, rx_iq_valid,
    output rx_bb_is_ongoing, rx_busy_ext, pulse_rx_bb_end, rx_timeout_pulse,
           rx_abort_by_tx, rx_rf_end_delay, rx_sample_count
  );
endinterface

// File: rtl/rx_on_detection_us_watchdog.sv
// Microsecond watchdog: counts 1 us ticks while enabled, flags the tick that
// makes the count reach limit_i. A zero limit disables the hit.
module rx_us_watchdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         tick_i,
  input  logic [W-1:0] limit_i,
  output logic         hit_o,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (en_i && tick_i) cnt_d = cnt_q + W'(1);
  end

  // Hit is flagged on the tick itself so the registered pulse lands one cycle later.
  assign hit_o = en_i && tick_i && (limit_i != '0) && ((cnt_q + W'(1)) == limit_i);
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/rx_on_detection.sv
// RX burst tracker: IDLE/ACTIVE/TAIL FSM with self-RX suppression, us watchdog
// and busy-tail extension. RX_IQ_GAP_END_EN adds an IQ-strobe-gap burst end.
module rx_on_detection
  import rx_on_detection_pkg::*;
#(
  parameter int COUNT_SCALE  = COUNT_SCALE_DEF,
  parameter int SAMPLE_CNT_W = 16,
  parameter int IQ_GAP_TOP   = 200
) (
  input logic               clk,
  input logic               rstn,
  rx_on_detection_if.slave  bus
);
  if (IQ_GAP_TOP < 1) begin : g_bad_gap
    $error("IQ_GAP_TOP must be at least 1");
  end

  rx_det_state_e           state_q;
  logic [SCALED_W-1:0]     delay_scale_q, tail_scale_q, tail_cnt_q, end_delay_q;
  logic [SAMPLE_CNT_W-1:0] sample_cnt_q, sample_inc;
  logic                    ongoing_q, busy_q, end_pulse_q, timeout_q, abort_q;
  logic                    start_ok, gap_hit, wd_hit, wd_clr, wd_en, tail_last;
  logic [15:0]             wd_cnt;

`ifdef RX_IQ_GAP_END_EN
  localparam int GAP_W = $clog2(IQ_GAP_TOP + 1);
  logic [GAP_W-1:0] gap_cnt_q;
  assign gap_hit = !bus.rx_iq_valid && (gap_cnt_q == GAP_W'(IQ_GAP_TOP - 1));
`else
  assign gap_hit = 1'b0;
`endif

  assign start_ok   = bus.phy_rx_started && !bus.tx_rf_is_ongoing;
  assign sample_inc = sample_cnt_q +
                      SAMPLE_CNT_W'(bus.rx_iq_valid && (sample_cnt_q != '1));
  assign tail_last  = ({1'b0, tail_cnt_q} + 15'd1) >= {1'b0, tail_scale_q};
  assign wd_en      = (state_q == RX_DET_ACTIVE);

  // Watchdog is cleared only when a start actually (re)opens a burst.
  always_comb begin
    wd_clr = 1'b0;
    case (state_q)
      RX_DET_IDLE, RX_DET_TAIL: wd_clr = start_ok;
      RX_DET_ACTIVE: wd_clr = start_ok && !bus.phy_rx_done && !gap_hit && !wd_hit;
      default: wd_clr = 1'b0;
    endcase
  end

  rx_us_watchdog #(.W(16)) u_wd (
    .clk     (clk),
    .rstn    (rstn),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .tick_i  (bus.tsf_pulse_1M),
    .limit_i (bus.rx_timeout_count_top),
    .hit_o   (wd_hit),
    .cnt_o   (wd_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= RX_DET_IDLE;
      delay_scale_q <= '0;
      tail_scale_q  <= '0;
      tail_cnt_q    <= '0;
      end_delay_q   <= '0;
      sample_cnt_q  <= '0;
      ongoing_q     <= 1'b0;
      busy_q        <= 1'b0;
      end_pulse_q   <= 1'b0;
      timeout_q     <= 1'b0;
      abort_q       <= 1'b0;
`ifdef RX_IQ_GAP_END_EN
      gap_cnt_q     <= '0;
`endif
    end else begin
      delay_scale_q <= scale_count(bus.bb_rf_delay_count_top, COUNT_SCALE);
      tail_scale_q  <= scale_count({4'd0, bus.rx_end_ext_count_top}, COUNT_SCALE);
      end_pulse_q   <= 1'b0;
      timeout_q     <= 1'b0;
      abort_q       <= 1'b0;
      case (state_q)
        RX_DET_IDLE: begin
          if (start_ok) begin
            state_q      <= RX_DET_ACTIVE;
            ongoing_q    <= 1'b1;
            busy_q       <= 1'b1;
            sample_cnt_q <= SAMPLE_CNT_W'(bus.rx_iq_valid);
`ifdef RX_IQ_GAP_END_EN
            gap_cnt_q    <= '0;
`endif
          end
        end
        RX_DET_ACTIVE: begin
          sample_cnt_q <= sample_inc;
`ifdef RX_IQ_GAP_END_EN
          gap_cnt_q    <= bus.rx_iq_valid ? '0 : gap_cnt_q + GAP_W'(1);
`endif
          if (bus.tx_rf_is_ongoing) begin
            state_q     <= RX_DET_IDLE;
            ongoing_q   <= 1'b0;
            busy_q      <= 1'b0;
            abort_q     <= 1'b1;
            end_pulse_q <= 1'b1;
            end_delay_q <= delay_scale_q;
          end else if (bus.phy_rx_done || gap_hit || wd_hit) begin
            state_q     <= RX_DET_TAIL;
            ongoing_q   <= 1'b0;
            tail_cnt_q  <= '0;
            end_pulse_q <= 1'b1;
            timeout_q   <= wd_hit && !bus.phy_rx_done && !gap_hit;
            end_delay_q <= delay_scale_q;
          end else if (start_ok) begin
            sample_cnt_q <= SAMPLE_CNT_W'(bus.rx_iq_valid);
`ifdef RX_IQ_GAP_END_EN
            gap_cnt_q    <= '0;
`endif
          end
        end
        RX_DET_TAIL: begin
          if (bus.tx_rf_is_ongoing) begin
            state_q <= RX_DET_IDLE;
            busy_q  <= 1'b0;
          end else if (start_ok) begin
            state_q      <= RX_DET_ACTIVE;
            ongoing_q    <= 1'b1;
            sample_cnt_q <= SAMPLE_CNT_W'(bus.rx_iq_valid);
`ifdef RX_IQ_GAP_END_EN
            gap_cnt_q    <= '0;
`endif
          end else if (tail_last) begin
            state_q <= RX_DET_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tail_cnt_q <= tail_cnt_q + SCALED_W'(1);
          end
        end
        default: begin
          state_q   <= RX_DET_IDLE;
          ongoing_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_bb_is_ongoing = ongoing_q;
  assign bus.rx_busy_ext      = busy_q;
  assign bus.pulse_rx_bb_end  = end_pulse_q;
  assign bus.rx_timeout_pulse = timeout_q;
  assign bus.rx_abort_by_tx   = abort_q;
  assign bus.rx_rf_end_delay  = end_delay_q;
  assign bus.rx_sample_count  = sample_cnt_q;
endmodule
